// File: rtl/muldiv4_ctrl_if.sv
// Request/response/core bundle between a requester, the muldiv4 controller and its combinational core.
// No logic inside; it only groups the signals.
// The slave modport is the controller view, and the master modport is the requester/core view.
interface muldiv4_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_signed;
  logic       req_div;
  logic [3:0] core_a;
  logic [3:0] core_b;
  logic       core_signed;
  logic       core_div;
  logic [7:0] core_result;
  logic       core_ediv0;
  logic       core_eover;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ediv0;
  logic       rsp_eover;
  logic       busy;
  logic       err_clr;
  logic [7:0] err_count;

  modport slave (
    input  req_valid, req_a, req_b, req_signed, req_div,
    output req_ready,
    output core_a, core_b, core_signed, core_div,
    input  core_result, core_ediv0, core_eover,
    output rsp_valid, rsp_data, rsp_ediv0, rsp_eover,
    input  rsp_ready,
    output busy, err_count,
    input  err_clr
  );

  modport master (
    output req_valid, req_a, req_b, req_signed, req_div,
    input  req_ready,
    input  core_a, core_b, core_signed, core_div,
    output core_result, core_ediv0, core_eover,
    input  rsp_valid, rsp_data, rsp_ediv0, rsp_eover,
    output rsp_ready,
    input  busy, err_count,
    output err_clr
  );
endinterface

// File: rtl/muldiv4_ctrl.sv
// Sequencer around a combinational 4-bit mul/div core: it latches operands, waits SETTLE cycles and captures the result.
// Latency: an accept on edge k gives rsp_valid after edge k+SETTLE. A new request can be accepted on the edge that retires a response.
// Backpressure: the response is held while rsp_ready=0, and req_ready stays low until the consumer takes the response.
module muldiv4_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  muldiv4_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [2:0] CNT_LOAD = 3'(SETTLE);

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_core_a;
  logic [3:0] r_core_b;
  logic       r_core_signed;
  logic       r_core_div;
  logic [7:0] r_rsp_data;
  logic       r_rsp_ediv0;
  logic       r_rsp_eover;
  logic [7:0] r_err_count;

  logic       w_req_ready;
  logic       w_accept;
  logic       w_capture;
  logic       w_cap_ediv0;
  logic       w_cap_eover;

  // Accept while idle, or while a held result is being taken. Reset keeps req_ready low.
  assign w_req_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.rsp_ready));
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_capture   = (r_state == S_SETTLE) && (r_cnt == 3'd1);
  // Core flags are meaningless for multiply, so they are masked before capture.
  assign w_cap_ediv0 = bus.core_ediv0 && r_core_div;
  assign w_cap_eover = bus.core_eover && r_core_div;

  // State and settle counter sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            if (w_accept) begin
              r_state <= S_SETTLE;
              r_cnt   <= CNT_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Operands are held at the core from one accept until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_a      <= 4'd0;
      r_core_b      <= 4'd0;
      r_core_signed <= 1'b0;
      r_core_div    <= 1'b0;
    end else if (w_accept) begin
      r_core_a      <= bus.req_a;
      r_core_b      <= bus.req_b;
      r_core_signed <= bus.req_signed;
      r_core_div    <= bus.req_div;
    end
  end

  // The result is captured on the last settle edge and retained until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data  <= 8'h00;
      r_rsp_ediv0 <= 1'b0;
      r_rsp_eover <= 1'b0;
    end else if (w_capture) begin
      r_rsp_data  <= bus.core_result;
      r_rsp_ediv0 <= w_cap_ediv0;
      r_rsp_eover <= w_cap_eover;
    end
  end

  // Saturating error counter. A clear wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (bus.err_clr) begin
      r_err_count <= 8'd0;
    end else if (w_capture && (w_cap_ediv0 || w_cap_eover) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.core_a      = r_core_a;
  assign bus.core_b      = r_core_b;
  assign bus.core_signed = r_core_signed;
  assign bus.core_div    = r_core_div;
  assign bus.rsp_valid   = (r_state == S_HOLD);
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_ediv0   = r_rsp_ediv0;
  assign bus.rsp_eover   = r_rsp_eover;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.err_count   = r_err_count;
endmodule

// File: tb/tb_muldiv4_ctrl.sv
// Bench for muldiv4_ctrl with two instances, SETTLE=1 and SETTLE=3.
// An arithmetic model of 4-bit mul/div serves both as the core stub and as the expected response.
module tb_muldiv4_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv4_ctrl_if if1();
  muldiv4_ctrl_if if3();

  muldiv4_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  muldiv4_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int total = 0;
  int bad   = 0;
  int em [2];
  int lat;
  logic sel = 1'b0;

  logic       req_valid = 1'b0;
  logic [3:0] req_a = 4'd0;
  logic [3:0] req_b = 4'd0;
  logic       req_signed = 1'b0;
  logic       req_div = 1'b0;
  logic       rsp_ready = 1'b1;
  logic       err_clr = 1'b0;

  logic [7:0] exp_data;
  logic       exp_e0;
  logic       exp_eo;

  // Reference arithmetic: result {ediv0, eover, data}. A divide gives {remainder, quotient}.
  function automatic logic [9:0] ref_op(input logic [3:0] a, input logic [3:0] b,
                                        input logic s, input logic d);
    int ia;
    int ib;
    int q;
    int r;
    logic e0;
    logic eo;
    logic [7:0] res;
    ia = (s && a >= 4'd8) ? int'(a) - 16 : int'(a);
    ib = (s && b >= 4'd8) ? int'(b) - 16 : int'(b);
    e0 = (b == 4'd0);
    eo = s && (ia == -8) && (ib == -1);
    if (!d) begin
      res = 8'(ia * ib);
    end else if (e0) begin
      res = {a, 4'hF};
    end else if (eo) begin
      res = 8'h08;
    end else begin
      q = ia / ib;
      r = ia % ib;
      res = {4'(r), 4'(q)};
    end
    return {e0, eo, res};
  endfunction

  always_comb {if1.core_ediv0, if1.core_eover, if1.core_result} =
    ref_op(if1.core_a, if1.core_b, if1.core_signed, if1.core_div);
  always_comb {if3.core_ediv0, if3.core_eover, if3.core_result} =
    ref_op(if3.core_a, if3.core_b, if3.core_signed, if3.core_div);

  assign if1.req_valid  = req_valid & ~sel;
  assign if3.req_valid  = req_valid & sel;
  assign if1.rsp_ready  = sel ? 1'b1 : rsp_ready;
  assign if3.rsp_ready  = sel ? rsp_ready : 1'b1;
  assign if1.req_a = req_a;  assign if3.req_a = req_a;
  assign if1.req_b = req_b;  assign if3.req_b = req_b;
  assign if1.req_signed = req_signed;  assign if3.req_signed = req_signed;
  assign if1.req_div = req_div;  assign if3.req_div = req_div;
  assign if1.err_clr = err_clr;  assign if3.err_clr = err_clr;

  logic       m_req_ready, m_rsp_valid, m_busy, m_e0, m_eo;
  logic [7:0] m_data, m_err;
  logic [3:0] m_core_a;
  assign m_req_ready = sel ? if3.req_ready : if1.req_ready;
  assign m_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
  assign m_busy      = sel ? if3.busy      : if1.busy;
  assign m_e0        = sel ? if3.rsp_ediv0 : if1.rsp_ediv0;
  assign m_eo        = sel ? if3.rsp_eover : if1.rsp_eover;
  assign m_data      = sel ? if3.rsp_data  : if1.rsp_data;
  assign m_err       = sel ? if3.err_count : if1.err_count;
  assign m_core_a    = sel ? if3.core_a    : if1.core_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [3:0] a, input logic [3:0] b, input logic s, input logic d);
    logic [9:0] r;
    r = ref_op(a, b, s, d);
    exp_data = r[7:0];
    exp_e0   = d ? r[9] : 1'b0;
    exp_eo   = d ? r[8] : 1'b0;
  endtask

  // Offer a request and return at the negedge that follows its accept edge.
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic s, input logic d);
    int n;
    req_a = a; req_b = b; req_signed = s; req_div = d; req_valid = 1'b1;
    n = 0;
    #1;
    while (!m_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(m_req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    set_exp(a, b, s, d);
  endtask

  // Count edges from the accept to rsp_valid, then check the captured response.
  task automatic await_rsp();
    int n;
    n = 0;
    while (!m_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("rsp_data", 32'(m_data), 32'(exp_data));
    chk("rsp_ediv0", 32'(m_e0), 32'(exp_e0));
    chk("rsp_eover", 32'(m_eo), 32'(exp_eo));
    if (err_clr) em[sel] = 0;
    else if (exp_e0 || exp_eo) em[sel] = (em[sel] >= 255) ? 255 : em[sel] + 1;
    chk("err_count", 32'(m_err), 32'(em[sel]));
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic s, input logic d);
    launch(a, b, s, d);
    await_rsp();
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic rs, rd;
    logic [7:0] held;
    int st;
    em[0] = 0; em[1] = 0;
    lat = 1;
    #1;
    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_rsp_data", 32'(m_data), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_core_a", 32'(m_core_a), 32'd0);
    chk("rst_req_ready_low", 32'(m_req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 32'(m_req_ready), 32'd1);
    @(negedge clk);

    // Directed cases on SETTLE=1.
    op(4'd7, 4'd9, 1'b0, 1'b0);
    chk("mul7x9_const", 32'(m_data), 32'h3F);
    op(4'h9, 4'h2, 1'b1, 1'b1);
    chk("sdiv_m7_2_const", 32'(m_data), 32'hFD);
    op(4'h5, 4'h0, 1'b0, 1'b0);
    chk("mul_flags_masked", 32'({m_e0, m_eo}), 32'd0);
    op(4'h6, 4'h0, 1'b0, 1'b1);
    chk("div0_flag", 32'(m_e0), 32'd1);
    chk("div0_err_one", 32'(m_err), 32'd1);
    err_clr = 1'b1;
    op(4'h3, 4'h0, 1'b1, 1'b1);
    chk("clr_beats_inc", 32'(m_err), 32'd0);
    err_clr = 1'b0;

    // Random traffic with occasional consumer stalls.
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      rs = 1'($urandom); rd = 1'($urandom);
      op(ra, rb, rs, rd);
      st = $urandom_range(0, 2);
      if (st != 0) begin
        rsp_ready = 1'b0;
        repeat (st) begin
          @(negedge clk);
          chk("stall_valid", 32'(m_rsp_valid), 32'd1);
          chk("stall_data", 32'(m_data), 32'(exp_data));
        end
        rsp_ready = 1'b1;
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // Saturation: -8 / -1 overflows every time.
    for (int i = 0; i < 256; i++) op(4'h8, 4'hF, 1'b1, 1'b1);
    chk("err_saturated", 32'(m_err), 32'd255);
    @(negedge clk);

    // SETTLE=3 instance.
    sel = 1'b1;
    lat = 3;
    #1;
    op(4'hB, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b0;
    op(4'hD, 4'h3, 1'b0, 1'b0);
    held = exp_data;
    req_a = 4'h6; req_b = 4'h7; req_signed = 1'b1; req_div = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_req_ready", 32'(m_req_ready), 32'd0);
      chk("hold_valid", 32'(m_rsp_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(held));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_req_ready", 32'(m_req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_busy", 32'(m_busy), 32'd1);
    chk("b2b_valid_drop", 32'(m_rsp_valid), 32'd0);
    chk("b2b_core_a", 32'(m_core_a), 32'h6);
    chk("retain_data", 32'(m_data), 32'(held));
    set_exp(4'h6, 4'h7, 1'b1, 1'b1);
    await_rsp();
    for (int i = 0; i < 6; i++) begin
      op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of SETTLE: async clear and no response later.
    op(4'hE, 4'h0, 1'b0, 1'b1);
    launch(4'hC, 4'h5, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(m_busy), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_err", 32'(m_err), 32'd0);
    chk("mid_rst_core_a", 32'(m_core_a), 32'd0);
    chk("mid_rst_e0", 32'(m_e0), 32'd0);
    em[0] = 0; em[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    st = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_rsp_valid) st++;
    end
    chk("no_rsp_after_rst", 32'(st), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv4_ctrl.md
MULDIV4_CTRL -- requirements
Module: muldiv4_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning core settle cycles between operand launch and result capture (legal 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  operation request offered.
REQ-005 SHALL have port req_ready  output  1  request accepted on an edge where req_valid=1.
REQ-006 SHALL have port req_a  input  4  multiplicand / dividend.
REQ-007 SHALL have port req_b  input  4  multiplier / divisor.
REQ-008 SHALL have port req_signed  input  1  0=unsigned, 1=signed.
REQ-009 SHALL have port req_div  input  1  0=multiply, 1=divide.
REQ-010 SHALL have ports core_a, core_b  output  4 each  registered operands driven into the combinational 4-bit mul/div core.
REQ-011 SHALL have ports core_signed, core_div  output  1 each  registered mode bits to the core.
REQ-012 SHALL have port core_result  input  8  core output (product, or {remainder,quotient}).
REQ-013 SHALL have ports core_ediv0, core_eover  input  1 each  core divide-by-zero / overflow flags.
REQ-014 SHALL have port rsp_valid  output  1  result held and offered.
REQ-015 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-016 SHALL have port rsp_data  output  8  captured result.
REQ-017 SHALL have ports rsp_ediv0, rsp_eover  output  1 each  captured error flags.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-020 SHALL have port err_count  output  8  saturating count of results carrying any error flag.

Function
REQ-021 SHALL implement states IDLE, SETTLE, HOLD.
REQ-022 SHALL assert req_ready in IDLE, and in HOLD only while rsp_ready=1; deassert in SETTLE.
REQ-023 SHALL, on an accept edge (req_valid & req_ready), load core_a/b/signed/div from req_* and enter SETTLE with settle counter = SETTLE.
REQ-024 SHALL hold core_* stable from accept until the next accept.
REQ-025 SHALL, in SETTLE, decrement the counter each edge; on the edge where it equals 1, capture core_result/core_ediv0/core_eover into rsp_* and enter HOLD.
REQ-026 SHALL give latency: accept on edge k -> rsp_valid high after edge k+SETTLE.
REQ-027 SHALL force captured rsp_ediv0 and rsp_eover to 0 when core_div=0.
REQ-028 SHALL assert rsp_valid only in HOLD; rsp_data and flags are stable while rsp_valid=1 and rsp_ready=0.
REQ-029 SHALL, in HOLD with rsp_ready=1 and req_valid=0, go to IDLE; with rsp_ready=1 and req_valid=1, accept the new request on that edge and go directly to SETTLE (back-to-back, zero bubble on the request side).
REQ-030 SHALL retain rsp_data and flags after leaving HOLD until the next capture.
REQ-031 SHALL increment err_count on each capture edge where the captured (post-REQ-027) rsp_ediv0|rsp_eover=1, saturating at 255.
REQ-032 SHALL give err_clr priority over a simultaneous increment (result 0).
REQ-033 SHALL not evaluate operands itself; divide-by-zero still runs the full SETTLE sequence.

Reset
REQ-034 SHALL, while rst=1, immediately force state IDLE, counter 0, core_* 0, rsp_valid 0, rsp_data 0x00, rsp flags 0, err_count 0, busy 0; req_ready is 1 when rst=0 and state is IDLE.
REQ-035 SHALL abandon any in-flight operation on reset with no response emitted.

Verification
REQ-036 SHALL cover: SETTLE=1, unsigned mul a=7 b=9, rsp_ready=1 -> rsp_valid one cycle after accept, rsp_data=0x3F, flags 0, err_count 0.
REQ-037 SHALL cover: signed div a=0xF9(-7 as 4-bit 0x9) b=0x2 -> rsp_data=0xFD ({r=-1,q=-3}), flags 0.
REQ-038 SHALL cover: div b=0 -> rsp_ediv0=1, err_count 0->1; then err_clr together with an error capture -> err_count=0.
REQ-039 SHALL cover: SETTLE=3, rsp_ready held 0 for 5 cycles -> req_ready=0, rsp_data stable; then rsp_ready=1 with req_valid=1 -> new request accepted on same edge, busy stays 1.
REQ-040 SHALL cover: rst pulsed mid-SETTLE -> all outputs at reset values asynchronously, no rsp_valid pulse afterwards.
REQ-041 SHALL cover: 256 consecutive signed div -8/-1 (overflow) -> err_count saturates at 255.
